// File: rtl/slc3_mem_arbiter.sv
// rtl/slc3_mem_arbiter.sv - two-port req/ack arbiter in front of the SLC-3 single-port BRAM
// Optional grant statistics: define SLC3_MEM_ARB_STATS_EN.
module slc3_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int READ_LAT   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic              busy,
    output logic [15:0]       cpu_grant_cnt,
    output logic [15:0]       dbg_grant_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [2:0] WAIT_INIT  = 3'(READ_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [2:0]          wait_cnt_q, wait_cnt_d;
    logic [3:0]          starve_cnt_q, starve_cnt_d;
    logic                bram_en_q, bram_en_d;
    logic                bram_we_q, bram_we_d;
    logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0]   bram_wdata_q, bram_wdata_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                dbg_ack_q, dbg_ack_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic                busy_q, busy_d;
    logic                grant;
    logic                dbg_win;

    assign grant   = (state_q == S_IDLE) && (cpu_req || dbg_req);
    // CPU has priority unless the debug port has been passed over STARVE_MAX times.
    assign dbg_win = dbg_req && (!cpu_req || (starve_cnt_q == STARVE_LIM));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        wait_cnt_d   = wait_cnt_q;
        starve_cnt_d = starve_cnt_q;
        bram_en_d    = 1'b0;
        bram_we_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
        bram_wdata_d = bram_wdata_q;
        cpu_ack_d    = 1'b0;
        dbg_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        busy_d       = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (grant) begin
                    busy_d       = 1'b1;
                    state_d      = S_ISSUE;
                    owner_d      = dbg_win;
                    bram_en_d    = 1'b1;
                    bram_we_d    = dbg_win ? dbg_we    : cpu_we;
                    bram_addr_d  = dbg_win ? dbg_addr  : cpu_addr;
                    bram_wdata_d = dbg_win ? dbg_wdata : cpu_wdata;
                    if (dbg_win || !dbg_req)
                        starve_cnt_d = 4'd0;
                    else if (starve_cnt_q != STARVE_LIM)
                        starve_cnt_d = starve_cnt_q + 4'd1;
                end
            end
            S_ISSUE: begin
                if (bram_we_q) begin
                    state_d   = S_DONE;
                    cpu_ack_d = !owner_q;
                    dbg_ack_d = owner_q;
                end else begin
                    state_d    = S_WAIT;
                    wait_cnt_d = WAIT_INIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d   = S_DONE;
                    cpu_ack_d = !owner_q;
                    dbg_ack_d = owner_q;
                    if (owner_q)
                        dbg_rdata_d = bram_rdata;
                    else
                        cpu_rdata_d = bram_rdata;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            wait_cnt_q   <= 3'd0;
            starve_cnt_q <= 4'd0;
            bram_en_q    <= 1'b0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_wdata_q <= '0;
            cpu_ack_q    <= 1'b0;
            dbg_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            bram_en_q    <= bram_en_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            dbg_ack_q    <= dbg_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bram_en    = bram_en_q;
    assign bram_we    = bram_we_q;
    assign bram_addr  = bram_addr_q;
    assign bram_wdata = bram_wdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign dbg_ack    = dbg_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign busy       = busy_q;

`ifdef SLC3_MEM_ARB_STATS_EN
    logic [15:0] cpu_cnt_q, cpu_cnt_d;
    logic [15:0] dbg_cnt_q, dbg_cnt_d;

    always_comb begin
        cpu_cnt_d = cpu_cnt_q;
        dbg_cnt_d = dbg_cnt_q;
        if (grant) begin
            if (dbg_win && dbg_cnt_q != 16'hFFFF)
                dbg_cnt_d = dbg_cnt_q + 16'd1;
            else if (!dbg_win && cpu_cnt_q != 16'hFFFF)
                cpu_cnt_d = cpu_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cpu_cnt_q <= 16'd0;
            dbg_cnt_q <= 16'd0;
        end else begin
            cpu_cnt_q <= cpu_cnt_d;
            dbg_cnt_q <= dbg_cnt_d;
        end
    end

    assign cpu_grant_cnt = cpu_cnt_q;
    assign dbg_grant_cnt = dbg_cnt_q;
`else
    assign cpu_grant_cnt = 16'd0;
    assign dbg_grant_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// tb/tb_slc3_mem_arbiter.sv - directed and randomized checks of slc3_mem_arbiter against a transaction-level model
module tb_slc3_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int RL = 2;
    localparam int SM = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;
    logic          cpu_ack, dbg_ack;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          bram_en, bram_we, busy;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic [DW-1:0] bram_rdata = '0;
    logic [DW-1:0] arr_q = '0;
    logic [15:0]   cpu_grant_cnt, dbg_grant_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int m_starve = 0;
    int m_cpu_g  = 0;
    int m_dbg_g  = 0;

    logic [DW-1:0] bram_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem  [logic [AW-1:0]];

    slc3_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .STARVE_MAX(SM)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_rdata(bram_rdata), .busy(busy),
        .cpu_grant_cnt(cpu_grant_cnt), .dbg_grant_cnt(dbg_grant_cnt)
    );

    always #5 Clk = ~Clk;

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return (a * 16'h9E37) ^ 16'h5AA5;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // BRAM with one array stage plus an output register
    always @(posedge Clk) begin
        if (bram_en) begin
            if (bram_we)
                bram_mem[bram_addr] = bram_wdata;
            else
                arr_q <= bram_mem.exists(bram_addr) ? bram_mem[bram_addr] : dflt(bram_addr);
        end
        bram_rdata <= arr_q;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input bit port, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
        int lat = 0;
        int wr_cyc = 0;
        logic [DW-1:0] other_rd;
        other_rd = port ? cpu_rdata : dbg_rdata;
        if (port) begin
            dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        end
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge Clk); #1;
            if (bram_en && bram_we) begin
                wr_cyc++;
                chk("wr_addr", bram_addr, addr);
                chk("wr_data", bram_wdata, wdata);
            end
            chk("other_ack", port ? cpu_ack : dbg_ack, 1'b0);
            if (port ? dbg_ack : cpu_ack) lat = k;
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        chk(we ? "wr_latency" : "rd_latency", lat, we ? 2 : RL + 2);
        if (we) begin
            chk("wr_cycles", wr_cyc, 1);
            ref_mem[addr] = wdata;
        end else begin
            chk("rd_data", port ? dbg_rdata : cpu_rdata, ref_rd(addr));
        end
        chk("other_rdata_held", port ? cpu_rdata : dbg_rdata, other_rd);
        m_starve = 0;
        if (port) m_dbg_g++; else m_cpu_g++;
        @(posedge Clk); #1;
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int acks, last, pulses, lat;
        bit exp_d;
        logic [AW-1:0] a;

        Reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        bram_mem[16'h0003] = 16'h1234;
        ref_mem[16'h0003]  = 16'h1234;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_ctrl", {cpu_ack, dbg_ack, bram_en, bram_we, busy}, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
        @(negedge Clk) Reset = 1'b0;
        @(posedge Clk); #1;

        txn(0, 0, 16'h0003, 16'h0000);
        chk("first_read", cpu_rdata, 16'h1234);
        txn(0, 1, 16'h0010, 16'hBEEF);
        txn(0, 0, 16'h0010, 16'h0000);
        chk("read_back", cpu_rdata, 16'hBEEF);
        txn(1, 1, 16'hFFFF, 16'($urandom));
        txn(1, 0, 16'hFFFF, 16'h0000);
        txn(1, 0, 16'($urandom), 16'h0000);

        // Both ports continuously requesting reads
        acks = 0; last = -1;
        cpu_we = 0; dbg_we = 0;
        cpu_addr = 16'($urandom); dbg_addr = 16'($urandom);
        cpu_req = 1; dbg_req = 1;
        for (int cyc = 0; cyc < 200 && acks < 10; cyc++) begin
            @(posedge Clk); #1;
            if (cpu_ack || dbg_ack) begin
                chk("go_both_ack", {31'd0, cpu_ack & dbg_ack}, 0);
                exp_d = (m_starve == SM);
                m_starve = exp_d ? 0 : (m_starve < SM ? m_starve + 1 : SM);
                chk("go_owner", dbg_ack, exp_d);
                if (dbg_ack) begin
                    chk("go_drd", dbg_rdata, ref_rd(dbg_addr));
                    dbg_addr = 16'($urandom);
                end else begin
                    chk("go_crd", cpu_rdata, ref_rd(cpu_addr));
                    cpu_addr = 16'($urandom);
                end
                if (last >= 0) chk("go_gap", cyc - last, RL + 3);
                last = cyc;
                acks++;
            end
        end
        cpu_req = 0; dbg_req = 0;
        chk("go_count", acks, 10);
        @(posedge Clk); #1;

        // Reset during WAIT of a debug read
        dbg_we = 0; dbg_addr = 16'($urandom); dbg_req = 1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("pre_abort_busy", busy, 1'b1);
        #2 Reset = 1'b1;
        #1;
        chk("abort_ctrl", {cpu_ack, dbg_ack, bram_en, bram_we, busy}, 0);
        chk("abort_bus", {bram_addr, bram_wdata}, 0);
        chk("abort_rdata", {cpu_rdata, dbg_rdata}, 0);
        chk("abort_cnt", {cpu_grant_cnt, dbg_grant_cnt}, 0);
        dbg_req = 0;
        @(negedge Clk) Reset = 1'b0;
        m_starve = 0; m_cpu_g = 0; m_dbg_g = 0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge Clk); #1;
            if (dbg_ack) pulses++;
        end
        chk("abort_no_ack", pulses, 0);

        txn(1, 0, 16'($urandom), 16'h0000);

        // CPU request dropped during ISSUE
        a = 16'($urandom);
        cpu_we = 0; cpu_addr = a; cpu_req = 1;
        @(posedge Clk); #1;
        chk("drop_issue_busy", busy, 1'b1);
        cpu_req = 0;
        cpu_addr = ~a;
        pulses = 0; lat = 0;
        for (int k = 2; k < 10; k++) begin
            @(posedge Clk); #1;
            if (cpu_ack) begin pulses++; lat = k; end
        end
        m_cpu_g++;
        chk("drop_pulses", pulses, 1);
        chk("drop_latency", lat, RL + 2);
        chk("drop_rdata", cpu_rdata, ref_rd(a));
        chk("drop_busy", busy, 1'b0);

        for (int i = 0; i < 4; i++)
            txn(0, 1'($urandom), 16'($urandom), 16'($urandom));
        txn(1, 1'($urandom), 16'($urandom), 16'($urandom));

`ifdef SLC3_MEM_ARB_STATS_EN
        chk("cpu_grant_cnt", cpu_grant_cnt, m_cpu_g);
        chk("dbg_grant_cnt", dbg_grant_cnt, m_dbg_g);
`else
        chk("cpu_grant_cnt", cpu_grant_cnt, 0);
        chk("dbg_grant_cnt", dbg_grant_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/slc3_mem_arbiter.md
Name: slc3_mem_arbiter

Overview:
- Shares the single-port synchronous BRAM of the SLC-3 between two requesters: the CPU memory port (driven by the ISDU's Mem_OE/Mem_WE/MAR/MDR path) and a debug/loader port (switch-panel program loader).
- Absorbs the BRAM read latency, including its output register, so requesters see a simple req/ack handshake.
- Guarantees the debug port is never starved.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- READ_LAT, 2, cycles from the BRAM issue edge to valid bram_rdata (1 array + 1 output register); legal range 1..7.
- STARVE_MAX, 4, maximum consecutive CPU grants while dbg_req is pending; legal range 1..15.

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; sampled at grant
- cpu_addr  in  ADDR_W  CPU address; sampled at grant
- cpu_wdata  in  DATA_W  CPU write data; sampled at grant
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  CPU read data; valid with cpu_ack, held until the next CPU read completes
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata  same as the cpu_* ports, for the debug port
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_W  BRAM address
- bram_wdata  out  DATA_W  BRAM write data
- bram_rdata  in  DATA_W  BRAM registered read data
- busy  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered. On Reset, every output is 0, the state is IDLE, the starvation counter is 0 and both rdata registers are 0.
- IDLE: arbitrates when cpu_req or dbg_req is high.
  - The CPU wins by default.
  - The debug port wins if only dbg_req is high, or if starve_cnt == STARVE_MAX.
  - The winner's we/addr/wdata and a grant-owner bit are captured. Next state is ISSUE.
- starve_cnt:
  - Increments on each CPU grant made while dbg_req is high.
  - Clears on any debug grant, and on a CPU grant made while dbg_req is low.
  - Saturates at STARVE_MAX.
- ISSUE (exactly 1 cycle): bram_en = 1, bram_we = captured we, bram_addr/bram_wdata = captured values.
  - Write: next state is DONE.
  - Read: next state is WAIT with wait_cnt = READ_LAT-1.
- WAIT: bram_en = 0. Decrements wait_cnt. When wait_cnt == 0, bram_rdata is registered into the owner's rdata register and the next state is DONE.
  - With READ_LAT = 1, WAIT lasts 1 cycle and bram_rdata is sampled in that cycle.
- DONE (1 cycle): the owner's ack = 1; the other ack stays 0. Requests are ignored. Next state is IDLE.
- Latency:
  - Write: req seen in IDLE at cycle t; ISSUE at t+1; ack at t+2.
  - Read: ack at t+READ_LAT+2, which is t+4 at default.
- Throughput: one transaction per write every 3 cycles; one per read every READ_LAT+3 cycles.
- At most one BRAM access is outstanding. bram_we is never high outside ISSUE.
- Simultaneous requests are resolved by the starvation rule only. There is no tie alternation.
- A request dropped mid-transaction does not abort it: the access completes and ack still pulses. Inputs changing after grant have no effect.
- Asserted Reset mid-transaction aborts immediately to IDLE with all outputs 0. No ack is produced.
- Address wrap: addresses pass through unmodified. There is no bounds checking.

Optional Feature:
- Macro: SLC3_MEM_ARB_STATS_EN.
- When defined, the block has two extra outputs, cpu_grant_cnt and dbg_grant_cnt (16 bits each).
  - Each increments on its port's grant in IDLE and saturates at 16'hFFFF.
  - Both clear on Reset.
- When undefined, the ports still exist but are tied to 0, and no counter logic is generated.

Test Plan:
- Reset, then a CPU read at addr 16'h0003 with the BRAM model returning 16'h1234 → cpu_ack exactly 4 cycles after req is sampled, cpu_rdata = 16'h1234, dbg_ack stays 0.
- CPU write addr 16'h0010, data 16'hBEEF → exactly one cycle with bram_en = bram_we = 1 and the correct addr/data; cpu_ack 2 cycles after sampling; a following read returns 16'hBEEF.
- cpu_req and dbg_req held high continuously → grant order C, C, C, C, D, C, C, C, C, D; no third consecutive ack gap longer than the read period.
- Reset asserted during WAIT of a debug read → all outputs 0 within the same cycle (asynchronous); no dbg_ack; the next request is serviced normally.
- cpu_req dropped during ISSUE of a read → cpu_ack still pulses for 1 cycle; the arbiter returns to IDLE; busy = 0 afterwards.
- With SLC3_MEM_ARB_STATS_EN, 5 CPU and 2 debug transactions → cpu_grant_cnt = 5, dbg_grant_cnt = 2; without the macro, both read 0.
